// File: rtl/pht_controller.sv
// ---------------------------------------------------------------------------
// pht_controller
//
// Pattern-history-table controller. Keeps 2^IDX_BITS two-bit saturating
// counters in a single-access table. Two requesters share the table:
//   * fetch side:   lookup (read) requests, answered one cycle later
//   * execute side: branch-resolution updates, buffered in an in-order FIFO
//                   and applied later as one-cycle read-modify-write steps
// After reset an init sweep writes INIT_STATE into every entry, one per
// cycle. Neither port opens until the sweep has finished.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. Ready never depends on valid. A requester that raises
// valid holds it and its payload stable until the transfer happens.
//
// Ports
//   clock, reset_n          clock (rising edge), async active-low reset
//   lk_valid/lk_index       lookup request and table index
//   lk_ready                lookup may be accepted this cycle
//   pred_valid              prediction valid (one cycle per accepted lookup)
//   pred_counter/pred_taken counter read for the lookup, and its MSB
//   up_valid/up_index/up_taken  update request: index and resolved direction
//   up_ready                update may be accepted into the FIFO
//   busy                    init sweep in progress
//   q_count                 current update FIFO occupancy
// ---------------------------------------------------------------------------
module pht_controller #(
  parameter int          IDX_BITS   = 4,
  parameter int          QDEPTH     = 4,
  parameter logic [1:0]  INIT_STATE = 2'b10
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      lk_valid,
  input  logic [IDX_BITS-1:0]       lk_index,
  output logic                      lk_ready,
  output logic                      pred_valid,
  output logic                      pred_taken,
  output logic [1:0]                pred_counter,
  input  logic                      up_valid,
  input  logic [IDX_BITS-1:0]       up_index,
  input  logic                      up_taken,
  output logic                      up_ready,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int PW      = $clog2(QDEPTH);
  localparam int CW      = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  // -------------------------------------------------------------------------
  // Controller state
  // -------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [IDX_BITS-1:0] init_ptr;

  // -------------------------------------------------------------------------
  // Storage: counter table and update FIFO. Neither needs a reset: the
  // table is rewritten by the init sweep and FIFO slots are only read when
  // q_count says they hold a live entry.
  // -------------------------------------------------------------------------
  logic [1:0]          table_mem [ENTRIES];
  logic [IDX_BITS:0]   fifo_mem  [QDEPTH];   // {taken, index}
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  // -------------------------------------------------------------------------
  // Handshake and arbitration
  // -------------------------------------------------------------------------
  logic                in_run;
  logic                not_full;
  logic                lk_fire;
  logic                up_fire;
  logic                drain;
  logic [IDX_BITS:0]   head;
  logic [IDX_BITS-1:0] head_index;
  logic                head_taken;
  logic [1:0]          head_old;
  logic [1:0]          head_new;

  assign in_run   = (state == ST_RUN);
  assign not_full = (count != FULL);

  // Ready is a function of registered state only. A full FIFO closes the
  // lookup port, which guarantees the table is free for a drain that cycle.
  assign lk_ready = in_run && not_full;
  assign up_ready = in_run && not_full;
  assign busy     = !in_run;
  assign q_count  = count;

  assign lk_fire  = lk_valid && lk_ready;
  assign up_fire  = up_valid && up_ready;

  // Lookups own the table when accepted; otherwise the FIFO head drains.
  // count reflects edges already taken, so an entry written at the current
  // edge is only seen (and drained) from the following cycle on.
  assign drain    = in_run && !lk_fire && (count != '0);

  assign head       = fifo_mem[rd_ptr];
  assign head_index = head[IDX_BITS-1:0];
  assign head_taken = head[IDX_BITS];
  assign head_old   = table_mem[head_index];

  // Saturating two-bit counter step.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
    end
    return res;
  endfunction

  assign head_new = sat_step(head_old, head_taken);

  // -------------------------------------------------------------------------
  // FSM: INIT sweeps the table, RUN serves both ports.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (&init_ptr) begin
            state    <= ST_RUN;
            init_ptr <= '0;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state    <= ST_INIT;
          init_ptr <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Table write port: sweep write in INIT, RMW write of the drained entry in
  // RUN. The two never coincide because drain requires RUN.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!in_run) begin
      table_mem[init_ptr] <= INIT_STATE;
    end else if (drain) begin
      table_mem[head_index] <= head_new;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO slot write
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (up_fire) begin
      fifo_mem[wr_ptr] <= {up_taken, up_index};
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy. Reset flushes any queued updates.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (up_fire) wr_ptr <= wr_ptr + 1'b1;
      if (drain)   rd_ptr <= rd_ptr + 1'b1;
      case ({up_fire, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Prediction output register. The lookup sees the table as it stands at
  // the accepting edge; queued updates are deliberately not forwarded.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pred_valid   <= 1'b0;
      pred_counter <= 2'b00;
      pred_taken   <= 1'b0;
    end else begin
      pred_valid <= lk_fire;
      if (lk_fire) begin
        pred_counter <= table_mem[lk_index];
        pred_taken   <= table_mem[lk_index][1];
      end
    end
  end

endmodule

// File: tb/tb_pht_controller.sv
// ---------------------------------------------------------------------------
// tb_pht_controller
//
// Directed bench for pht_controller (IDX_BITS=4, QDEPTH=4, INIT_STATE=2'b10).
// A table of lookup/update records drives the main counter behaviour; short
// hand-written sequences cover init length, FIFO-full arbitration, the
// no-forwarding rule and reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_pht_controller;

  localparam int IDX_BITS = 4;
  localparam int QDEPTH   = 4;
  localparam int ENTRIES  = 1 << IDX_BITS;

  // ---------------- clock / reset ----------------
  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  always #5 clock = ~clock;

  logic                lk_valid = 1'b0;
  logic [IDX_BITS-1:0] lk_index = '0;
  logic                lk_ready;
  logic                pred_valid;
  logic                pred_taken;
  logic [1:0]          pred_counter;
  logic                up_valid = 1'b0;
  logic [IDX_BITS-1:0] up_index = '0;
  logic                up_taken = 1'b0;
  logic                up_ready;
  logic                busy;
  logic [$clog2(QDEPTH):0] q_count;

  pht_controller #(
    .IDX_BITS  (IDX_BITS),
    .QDEPTH    (QDEPTH),
    .INIT_STATE(2'b10)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .lk_valid    (lk_valid),
    .lk_index    (lk_index),
    .lk_ready    (lk_ready),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_counter(pred_counter),
    .up_valid    (up_valid),
    .up_index    (up_index),
    .up_taken    (up_taken),
    .up_ready    (up_ready),
    .busy        (busy),
    .q_count     (q_count)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_update(input logic [IDX_BITS-1:0] idx, input logic tk);
    int n;
    up_index = idx;
    up_taken = tk;
    up_valid = 1'b1;
    n = 0;
    while (!up_ready && n < 50) begin step(); n++; end
    if (!up_ready) check("up_ready_wait", up_ready, 1);
    step();
    up_valid = 1'b0;
    n = 0;
    while (q_count != 0 && n < 20) begin step(); n++; end
    if (q_count != 0) check("drain_wait", q_count, 0);
  endtask

  task automatic do_lookup(input logic [IDX_BITS-1:0] idx,
                           output logic pv, output logic [1:0] pc,
                           output logic pt);
    int n;
    lk_index = idx;
    lk_valid = 1'b1;
    n = 0;
    while (!lk_ready && n < 50) begin step(); n++; end
    if (!lk_ready) check("lk_ready_wait", lk_ready, 1);
    step();
    lk_valid = 1'b0;
    pv = pred_valid;
    pc = pred_counter;
    pt = pred_taken;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic                is_up;
    logic [IDX_BITS-1:0] idx;
    logic                taken;
    logic [1:0]          exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic set_vec(input int i, input logic u, input int idx,
                         input logic t, input logic [1:0] e);
    vecs[i].is_up = u;
    vecs[i].idx   = IDX_BITS'(idx);
    vecs[i].taken = t;
    vecs[i].exp   = e;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       pv;
    logic [1:0] pc;
    logic       pt;
    int         n;

    // lookups of fresh entries
    set_vec(0,  1'b0, 5,  1'b0, 2'b10);
    set_vec(1,  1'b0, 0,  1'b0, 2'b10);
    set_vec(2,  1'b0, 15, 1'b0, 2'b10);
    // index 3 saturation upward
    set_vec(3,  1'b1, 3,  1'b1, 2'b00);
    set_vec(4,  1'b1, 3,  1'b1, 2'b00);
    set_vec(5,  1'b1, 3,  1'b1, 2'b00);
    set_vec(6,  1'b0, 3,  1'b0, 2'b11);
    // index 3 downward to saturation
    set_vec(7,  1'b1, 3,  1'b0, 2'b00);
    set_vec(8,  1'b1, 3,  1'b0, 2'b00);
    set_vec(9,  1'b1, 3,  1'b0, 2'b00);
    set_vec(10, 1'b1, 3,  1'b0, 2'b00);
    set_vec(11, 1'b0, 3,  1'b0, 2'b00);
    set_vec(12, 1'b1, 3,  1'b0, 2'b00);
    set_vec(13, 1'b0, 3,  1'b0, 2'b00);
    // index 12: 10 -> 01 -> 10 -> 11 -> 11
    set_vec(14, 1'b1, 12, 1'b0, 2'b00);
    set_vec(15, 1'b0, 12, 1'b0, 2'b01);
    set_vec(16, 1'b1, 12, 1'b1, 2'b00);
    set_vec(17, 1'b1, 12, 1'b1, 2'b00);
    set_vec(18, 1'b1, 12, 1'b1, 2'b00);
    set_vec(19, 1'b0, 12, 1'b0, 2'b11);

    // ---------------- reset values ----------------
    #2;
    check("rst_lk_ready",     lk_ready,     0);
    check("rst_up_ready",     up_ready,     0);
    check("rst_pred_valid",   pred_valid,   0);
    check("rst_pred_taken",   pred_taken,   0);
    check("rst_pred_counter", pred_counter, 0);
    check("rst_busy",         busy,         1);
    check("rst_q_count",      q_count,      0);
    step();
    step();
    reset_n = 1'b1;

    // ---------------- init length ----------------
    n = 0;
    while (busy && n < 100) begin n++; step(); end
    check("init_busy_cycles", n, ENTRIES);
    check("init_lk_ready", lk_ready, 1);
    check("init_up_ready", up_ready, 1);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_up) begin
        do_update(vecs[i].idx, vecs[i].taken);
      end else begin
        step();
        do_lookup(vecs[i].idx, pv, pc, pt);
        check($sformatf("vec%0d_pred_valid", i), pv, 1);
        check($sformatf("vec%0d_counter", i), pc, vecs[i].exp);
        check($sformatf("vec%0d_taken", i), pt, vecs[i].exp[1]);
        step();
        check($sformatf("vec%0d_valid_drop", i), pred_valid, 0);
      end
    end

    // ---------------- arbitration with full FIFO ----------------
    lk_index = 4'd0;
    lk_valid = 1'b1;
    up_index = 4'd9;
    up_taken = 1'b1;
    up_valid = 1'b1;
    for (int i = 0; i < QDEPTH; i++) step();
    up_valid = 1'b0;
    check("full_q_count",    q_count,    QDEPTH);
    check("full_lk_ready",   lk_ready,   0);
    check("full_up_ready",   up_ready,   0);
    check("full_pred_valid", pred_valid, 1);
    step();
    check("after_full_q_count",    q_count,    QDEPTH - 1);
    check("after_full_lk_ready",   lk_ready,   1);
    check("after_full_up_ready",   up_ready,   1);
    check("after_full_pred_valid", pred_valid, 0);
    lk_valid = 1'b0;
    n = 0;
    while (q_count != 0 && n < 4) begin step(); n++; end
    check("full_drain_q_count", q_count, 0);
    step();
    do_lookup(4'd9, pv, pc, pt);
    check("idx9_counter", pc, 2'b11);
    check("idx9_taken",   pt, 1);

    // ---------------- no forwarding ----------------
    step();
    up_index = 4'd7;
    up_taken = 1'b1;
    up_valid = 1'b1;
    lk_index = 4'd7;
    lk_valid = 1'b1;
    step();
    up_valid = 1'b0;
    lk_valid = 1'b0;
    check("nofwd_pred_valid", pred_valid,   1);
    check("nofwd_counter",    pred_counter, 2'b10);
    check("nofwd_q_count",    q_count,      1);
    step();
    step();
    step();
    do_lookup(4'd7, pv, pc, pt);
    check("idx7_after_counter", pc, 2'b11);

    // ---------------- reset mid-operation ----------------
    step();
    lk_index = 4'd1;
    lk_valid = 1'b1;
    up_index = 4'd2;
    up_taken = 1'b1;
    up_valid = 1'b1;
    step();
    step();
    lk_valid = 1'b0;
    up_valid = 1'b0;
    check("pre_rst_q_count",    q_count,    2);
    check("pre_rst_pred_valid", pred_valid, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_q_count",    q_count,    0);
    check("midrst_pred_valid", pred_valid, 0);
    check("midrst_busy",       busy,       1);
    check("midrst_lk_ready",   lk_ready,   0);
    step();
    step();
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin n++; step(); end
    check("reinit_busy_cycles", n, ENTRIES);
    for (int i = 0; i < ENTRIES; i++) begin
      do_lookup(IDX_BITS'(i), pv, pc, pt);
      check($sformatf("reinit_idx%0d", i), pc, 2'b10);
    end

    // ---------------- report ----------------
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pht_controller.md
# pht_controller

Pattern-history-table controller for the branch-prediction path. Holds 2^IDX_BITS two-bit saturating counters in a single-access table and arbitrates it between a fetch-side lookup requester and an execute-side update requester. Branch resolutions are buffered in an update FIFO and applied as one-cycle read-modify-write steps. After reset, an init sweep loads every entry before either port is opened.

## Interface
- IDX_BITS, 4, table index width; table holds 2^IDX_BITS entries
- QDEPTH, 4, update FIFO depth; power of two, at least 2
- INIT_STATE, 2'b10, counter value written to every entry by the init sweep (weakly taken)

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- lk_valid  in  1  lookup request
- lk_index  in  IDX_BITS  lookup table index
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready at a rising edge
- pred_valid  out  1  prediction result valid, one cycle per accepted lookup
- pred_taken  out  1  prediction; equals pred_counter[1]
- pred_counter  out  2  counter value read for the lookup
- up_valid  in  1  branch-resolution update request
- up_index  in  IDX_BITS  index to update
- up_taken  in  1  resolved direction: 1 = taken
- up_ready  out  1  update accepted into the FIFO when up_valid && up_ready at a rising edge
- busy  out  1  init sweep in progress
- q_count  out  $clog2(QDEPTH)+1  current FIFO occupancy

## Operation
- States: INIT and RUN. Reset forces INIT with the sweep pointer at 0.
- INIT: one entry per cycle is written with INIT_STATE, at indices 0 to 2^IDX_BITS-1. After the last write, the state moves to RUN. During INIT, busy=1, lk_ready=0 and up_ready=0.
- RUN outputs: lk_ready = (q_count != QDEPTH); up_ready = (q_count != QDEPTH); busy=0.
- Table access limit: at most one access per cycle, either a lookup read or an update RMW, never both.
- Arbitration priority 1: an accepted lookup uses the table that cycle.
- Arbitration priority 2: if no lookup is accepted and q_count > 0, the FIFO head is dequeued and its entry is updated.
- Starvation bound: a full FIFO deasserts lk_ready, which forces a drain that cycle.
- Update arithmetic when taken: ctr = (ctr == 2'b11) ? 2'b11 : ctr + 1.
- Update arithmetic when not taken: ctr = (ctr == 2'b00) ? 2'b00 : ctr - 1.
- Counters saturate; they never wrap.
- No forwarding: a lookup returns the table contents at the cycle it is accepted. Updates still queued in the FIFO are not visible to it.
- FIFO is in-order; an entry is never dropped or merged. Simultaneous enqueue and dequeue leaves q_count unchanged.
- An entry enqueued at edge k is not eligible to drain until the cycle after edge k.
- Reset mid-operation, handled asynchronously:
  - flush the FIFO (q_count=0);
  - pred_valid=0 and any in-flight prediction is discarded;
  - return to INIT and sweep the whole table again.

## Timing
- Reset values: lk_ready=0, up_ready=0, pred_valid=0, pred_taken=0, pred_counter=2'b00, busy=1, q_count=0.
- Init duration: busy is high for exactly 2^IDX_BITS cycles after reset_n rises. lk_ready and up_ready may rise in the following cycle.
- Lookup latency is 1 cycle: acceptance at edge k gives pred_valid=1, with pred_counter and pred_taken, for the cycle after edge k. pred_valid deasserts when no lookup was accepted at the prior edge.
- Back-to-back lookups produce back-to-back predictions, one per cycle.
- Update visibility: update accepted at edge k, drained during the cycle after k, written at edge k+1. A lookup accepted at edge k+2 or later sees the new value, given no intervening lookups. Each cycle in which a lookup is accepted delays the drain by one cycle.
- Full FIFO: the cycle with q_count=QDEPTH has lk_ready=0 and up_ready=0, and a drain occurs. The next cycle has q_count=QDEPTH-1 with both ready signals high again.
- Ready signals depend only on registered state, with no combinational path from the valid inputs.

## Test plan
- Reset with IDX_BITS=4, then release reset_n: busy is high for 16 cycles. Then lookup index 5: the next cycle shows pred_valid=1, pred_counter=2'b10, pred_taken=1.
- Saturation on index 3, with no lookups between steps:
  - 3 taken updates, then lookup: 2'b11.
  - 4 not-taken updates, then lookup: 2'b00, pred_taken=0.
  - 1 more not-taken, then lookup: still 2'b00.
- Arbitration, with QDEPTH=4:
  - Hold lk_valid high continuously and push 4 taken updates to index 9: q_count reaches 4.
  - That cycle: lk_ready=0, up_ready=0.
  - The next cycle: q_count=3 and lk_ready=1.
  - After lk_valid drops, the FIFO drains fully within 4 cycles, and a lookup of index 9 then returns 2'b11.
- No forwarding:
  - Accept update (index 7, taken) and lookup index 7 at the same edge: the prediction is 2'b10.
  - With idle cycles after it, a lookup of index 7 then returns 2'b11.
- Reset mid-operation:
  - Set up 2 FIFO entries and a lookup accepted in the prior cycle, then pulse reset_n low: immediately q_count=0, pred_valid=0, busy=1.
  - After re-init, the earlier updates are absent; every entry reads 2'b10.
